// File: rtl/rect_motion_ctrl.sv
// Per-frame motion scheduler for the VGA rectangle: at vblank start it steps, bounces and
// commits the origin atomically. Define RECT_COLOR_CYCLE_EN to step the colour on each bounce.
module rect_motion_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RECT_W   = 160,
  parameter int RECT_H   = 160,
  parameter int INIT_X   = 240,
  parameter int INIT_Y   = 160,
  parameter int SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               run_en,
  input  logic [SPEED_W-1:0] speed,
  output logic [9:0]         rect_x,
  output logic [9:0]         rect_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [5:0]         rect_rgb,
  output logic               bounce
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STEP_X = 3'd2;
  localparam logic [2:0] S_STEP_Y = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [10:0] MAX_X      = 11'(H_ACTIVE - RECT_W);
  localparam logic [10:0] MAX_Y      = 11'(V_ACTIVE - RECT_H);
  localparam logic [5:0]  RGB_YELLOW = 6'b111100;

  // Result is {flip, next_pos}; the sum is 11 bits wide so the far edge clamps instead of wrapping.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [SPEED_W-1:0] spd, input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(spd);
    if (spd == '0)
      step_axis = {1'b0, pos};
    else if (dir)
      step_axis = (sum >= lim) ? {1'b1, lim[9:0]} : {1'b0, sum[9:0]};
    else
      step_axis = ({1'b0, pos} <= 11'(spd)) ? {1'b1, 10'd0} : {1'b0, pos - 10'(spd)};
  endfunction

  logic [2:0]         state_q, state_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [9:0]         next_x_q, next_x_d, next_y_q, next_y_d;
  logic               ndir_x_q, ndir_x_d, ndir_y_q, ndir_y_d;
  logic [9:0]         rect_x_q, rect_x_d, rect_y_q, rect_y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               bounce_q, bounce_d;
  logic               frame_tick, flip;
  logic [10:0]        sx, sy;

  assign frame_tick = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
  assign sx         = step_axis(rect_x_q, dir_x_q, spd_q, MAX_X);
  assign sy         = step_axis(rect_y_q, dir_y_q, spd_q, MAX_Y);
  assign flip       = (ndir_x_q != dir_x_q) || (ndir_y_q != dir_y_q);

  always_comb begin
    state_d  = state_q;
    spd_d    = spd_q;
    next_x_d = next_x_q;
    next_y_d = next_y_q;
    ndir_x_d = ndir_x_q;
    ndir_y_d = ndir_y_q;
    rect_x_d = rect_x_q;
    rect_y_d = rect_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = 1'b0;
    case (state_q)
      S_IDLE: if (run_en) state_d = S_WAIT;
      S_WAIT: begin
        if (frame_tick) begin
          state_d = S_STEP_X;
          spd_d   = speed;
        end else if (!run_en) begin
          state_d = S_IDLE;
        end
      end
      S_STEP_X: begin
        next_x_d = sx[9:0];
        ndir_x_d = dir_x_q ^ sx[10];
        state_d  = S_STEP_Y;
      end
      S_STEP_Y: begin
        next_y_d = sy[9:0];
        ndir_y_d = dir_y_q ^ sy[10];
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        rect_x_d = next_x_q;
        rect_y_d = next_y_q;
        dir_x_d  = ndir_x_q;
        dir_y_d  = ndir_y_q;
        bounce_d = flip;
        state_d  = run_en ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      spd_q    <= '0;
      next_x_q <= '0;
      next_y_q <= '0;
      ndir_x_q <= 1'b0;
      ndir_y_q <= 1'b0;
      rect_x_q <= 10'(INIT_X);
      rect_y_q <= 10'(INIT_Y);
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      spd_q    <= spd_d;
      next_x_q <= next_x_d;
      next_y_q <= next_y_d;
      ndir_x_q <= ndir_x_d;
      ndir_y_q <= ndir_y_d;
      rect_x_q <= rect_x_d;
      rect_y_q <= rect_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      bounce_q <= bounce_d;
    end
  end

`ifdef RECT_COLOR_CYCLE_EN
  logic [5:0] rgb_q, rgb_d;

  // yellow -> cyan -> magenta -> white -> yellow, stepping on the commit edge
  always_comb begin
    rgb_d = rgb_q;
    if (state_q == S_COMMIT && flip) begin
      case (rgb_q)
        6'b111100: rgb_d = 6'b001111;
        6'b001111: rgb_d = 6'b110011;
        6'b110011: rgb_d = 6'b111111;
        default:   rgb_d = RGB_YELLOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= RGB_YELLOW;
    else        rgb_q <= rgb_d;
  end

  assign rect_rgb = rgb_q;
`else
  assign rect_rgb = RGB_YELLOW;
`endif

  assign rect_x = rect_x_q;
  assign rect_y = rect_y_q;
  assign dir_x  = dir_x_q;
  assign dir_y  = dir_y_q;
  assign bounce = bounce_q;
endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Randomized scoreboard bench for rect_motion_ctrl: a frame-level model predicts each commit
// and the cycle it lands on; a negedge monitor checks every cycle against that prediction.
module tb_rect_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       run_en;
  logic [2:0] speed;
  logic [9:0] rect_x, rect_y;
  logic       dir_x, dir_y, bounce;
  logic [5:0] rect_rgb;

  rect_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .run_en(run_en), .speed(speed),
    .rect_x(rect_x), .rect_y(rect_y), .dir_x(dir_x), .dir_y(dir_y),
    .rect_rgb(rect_rgb), .bounce(bounce)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [28:0] v;
  } exp_t;

  localparam logic [28:0] RST_VEC = {10'd240, 10'd160, 1'b1, 1'b1, 6'b111100, 1'b0};

  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  logic [28:0] cur = RST_VEC;

  // frame-level model of the committed state
  int         mx, my;
  bit         mdx, mdy;
  logic [5:0] mrgb;

  function automatic logic [28:0] dut_vec();
    return {rect_x, rect_y, dir_x, dir_y, rect_rgb, bounce};
  endfunction

  task automatic check_vec(input string nm, input logic [28:0] act, input logic [28:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got x=%0d y=%0d dx=%b dy=%b rgb=%b b=%b, want x=%0d y=%0d dx=%b dy=%b rgb=%b b=%b",
               nm, cyc, act[28:19], act[18:9], act[8], act[7], act[6:1], act[0],
               exp[28:19], exp[18:9], exp[8], exp[7], exp[6:1], exp[0]);
    end
  endtask

  // Monitor: pops at the predicted commit cycle, otherwise outputs must hold with bounce low.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur = RST_VEC;
      check_vec("reset_state", dut_vec(), RST_VEC);
    end else begin
      if (q.size() > 0 && q[0].due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL commit_overdue: due cyc %0d, now cyc %0d", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check_vec("commit", dut_vec(), e.v);
        cur = {e.v[28:1], 1'b0};
      end else begin
        check_vec("hold", dut_vec(), cur);
      end
    end
  end

  task automatic axis(input int p, input bit d, input int s, input int lim,
                      output int np, output bit nd);
    np = p;
    nd = d;
    if (s != 0) begin
      if (d) begin
        if (p + s >= lim) begin np = lim; nd = 1'b0; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 1'b1; end
        else np = p - s;
      end
    end
  endtask

  task automatic model_reset();
    mx = 240; my = 160; mdx = 1'b1; mdy = 1'b1; mrgb = 6'b111100;
  endtask

  task automatic model_commit(input int s, input int due);
    int   nx, ny;
    bit   ndx, ndy, b;
    exp_t e;
    axis(mx, mdx, s, 640 - 160, nx, ndx);
    axis(my, mdy, s, 480 - 160, ny, ndy);
    b = (ndx != mdx) || (ndy != mdy);
`ifdef RECT_COLOR_CYCLE_EN
    if (b) begin
      case (mrgb)
        6'b111100: mrgb = 6'b001111;
        6'b001111: mrgb = 6'b110011;
        6'b110011: mrgb = 6'b111111;
        default:   mrgb = 6'b111100;
      endcase
    end
`endif
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
    e.due = due;
    e.v   = {10'(mx), 10'(my), mdx, mdy, mrgb, b};
    q.push_back(e);
  endtask

  // Non-tick beam positions, including near misses of the tick decode.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 3))
        0: begin hpos = 10'd0; vpos = 10'd479; end
        1: begin hpos = 10'd1; vpos = 10'd480; end
        default: begin
          hpos = 10'($urandom_range(0, 799));
          vpos = 10'($urandom_range(0, 524));
          if (hpos == 10'd0 && vpos == 10'd480) hpos = 10'd2;
        end
      endcase
    end
  endtask

  task automatic frame(input bit en, input int s, input bit drop);
    run_en = en;
    speed  = 3'(s);
    idle(3);
    @(posedge clk);
    #1;
    hpos = 10'd0;
    vpos = 10'd480;
    if (en) model_commit(s, cyc + 4);
    idle(1);
    speed = 3'($urandom);
    if (drop) run_en = 1'b0;
    idle(6);
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; speed = '0; hpos = 10'd1; vpos = 10'd0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // steady motion from reset, then drive x onto 478 and hit the right edge with speed 4
    repeat (3) frame(1'b1, 2, 1'b0);
    for (int k = 0; k < 200 && mx != 478; k++) frame(1'b1, 2, 1'b0);
    frame(1'b1, 4, 1'b0);
    frame(1'b1, 4, 1'b0);

    // held: run_en low, then running at speed 0
    repeat (5) frame(1'b0, 3, 1'b0);
    repeat (5) frame(1'b1, 0, 1'b0);

    // random speeds, run_en gaps and mid-sequence drops
    for (int k = 0; k < 500; k++)
      frame($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 4) == 0);

    // reset in STEP_Y: immediate reset values, pending commit discarded
    run_en = 1'b1;
    speed  = 3'd5;
    idle(3);
    @(posedge clk);
    #1;
    hpos = 10'd0;
    vpos = 10'd480;
    idle(2);
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", dut_vec(), RST_VEC);
    idle(2);
    rst_n = 1'b1;
    model_reset();
    idle(10);
    repeat (3) frame(1'b1, $urandom_range(1, 7), 1'b0);
    idle(10);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: %0d commits outstanding, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
